// File: rtl/adder_pkg.sv
// Shared helpers for adder_pipe: chunk sizing and saturation constants.
// Saturation (ADDER_PIPE_SAT_EN) is selected in adder_pipe; these helpers are build-independent.
package adder_pkg;

  localparam int MAX_WIDTH = 128;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Largest representable value: 0x7F..F when signed, all-ones when unsigned.
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int width, input bit is_signed);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width - (is_signed ? 1 : 0)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    r[width-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline stage of adder_pipe: adds chunk IDX of the operands plus the
// incoming carry, registers the payload, and drives its upstream ready.
module adder_pipe_stage
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_carry
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LO    = IDX * CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
    logic             valid;
  } payload_t;

  payload_t         q;
  logic [CHUNK:0]   part;
  logic [WIDTH-1:0] next_sum;

  assign part = {1'b0, in_a[LO +: CHUNK]} + {1'b0, in_b[LO +: CHUNK]}
              + {{CHUNK{1'b0}}, in_carry};

  // Chunks at and above IDX are still zero in the incoming partial sum.
  assign next_sum = in_sum | (WIDTH'(part[CHUNK-1:0]) << LO);

  assign in_ready = !q.valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (in_ready) begin
      q.valid <= in_valid;
      if (in_valid) begin
        q.sum   <= next_sum;
        q.a     <= in_a;
        q.b     <= in_b;
        q.carry <= part[CHUNK];
      end
    end
  end

  assign out_valid = q.valid;
  assign out_sum   = q.sum;
  assign out_a     = q.a;
  assign out_b     = q.b;
  assign out_carry = q.carry;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder with valid/ready handshake, carry-out and overflow.
// Optional ADDER_PIPE_SAT_EN makes sum saturate on overflow instead of wrapping.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [STAGES:0]  carry;
  logic [WIDTH-1:0] s_pipe [STAGES+1];
  logic [WIDTH-1:0] a_pipe [STAGES+1];
  logic [WIDTH-1:0] b_pipe [STAGES+1];

  assign vld[0]      = in_valid;
  assign carry[0]    = cin;
  assign s_pipe[0]   = '0;
  assign a_pipe[0]   = a;
  assign b_pipe[0]   = b;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_sum    (s_pipe[k]),
      .in_a      (a_pipe[k]),
      .in_b      (b_pipe[k]),
      .in_carry  (carry[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_sum   (s_pipe[k+1]),
      .out_a     (a_pipe[k+1]),
      .out_b     (b_pipe[k+1]),
      .out_carry (carry[k+1])
    );
  end

  logic [WIDTH-1:0] raw_sum;
  logic             a_msb;
  logic             b_msb;
  logic             signed_ovf;
  logic             unused_low_bits;

  assign raw_sum    = s_pipe[STAGES];
  assign a_msb      = a_pipe[STAGES][WIDTH-1];
  assign b_msb      = b_pipe[STAGES][WIDTH-1];
  assign signed_ovf = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);

  // Only the operand sign bits matter once the last chunk has been added.
  assign unused_low_bits = ^{a_pipe[STAGES][WIDTH-2:0], b_pipe[STAGES][WIDTH-2:0]};

  assign out_valid = vld[STAGES];
  assign cout      = carry[STAGES];
  assign ovf       = (SIGNED != 0) ? signed_ovf : cout;

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH, SIGNED != 0));
  localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

  // Negative signed overflow clamps low; everything else clamps high.
  always_comb begin
    sum = raw_sum;
    if (ovf) sum = ((SIGNED != 0) && a_msb) ? SAT_LO : SAT_HI;
  end
`else
  assign sum = raw_sum;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Directed self-checking bench for adder_pipe (WIDTH=8, STAGES=2, SIGNED=1).
// Expected sums follow ADDER_PIPE_SAT_EN when the bench is built with it.
module tb_adder_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int vectors;
  int miscompares;

  adder_pipe #(
    .WIDTH  (8),
    .STAGES (2),
    .SIGNED (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic c);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    step();
    in_valid = 1'b0;
  endtask

  // Reference result packed as {ovf, cout, sum}.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] full;
    logic       o;
    logic [7:0] s;
    full = {1'b0, x} + {1'b0, y} + {8'b0, c};
    o    = (x[7] == y[7]) && (full[7] != x[7]);
    s    = full[7:0];
`ifdef ADDER_PIPE_SAT_EN
    if (o) s = x[7] ? 8'h80 : 8'h7F;
`endif
    return {o, full[8], s};
  endfunction

  logic [9:0] exp_q[$];
  logic [9:0] exp_v;
  logic [7:0] results [4];
  logic [7:0] rx;
  logic [7:0] ry;
  logic       rc;
  logic       was_ready;
  int         accepted;
  int         got;
  int         first_out;
  int         last_out;
  int         outs;
  int         not_ready;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    out_ready   = 1'b1;

    step();
    step();
    checkOutput("reset_out_valid", {31'b0, out_valid}, 0);
    checkOutput("reset_sum", {24'b0, sum}, 0);
    checkOutput("reset_cout", {31'b0, cout}, 0);
    checkOutput("reset_ovf", {31'b0, ovf}, 0);
    #3 rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", {31'b0, in_ready}, 1);
    step();

    // Basic add with latency check
    applyStimulus(8'd100, 8'd27, 1'b0);
    checkOutput("basic_latency_1", {31'b0, out_valid}, 0);
    step();
    checkOutput("basic_out_valid", {31'b0, out_valid}, 1);
    checkOutput("basic_sum", {24'b0, sum}, 127);
    checkOutput("basic_cout", {31'b0, cout}, 0);
    checkOutput("basic_ovf", {31'b0, ovf}, 0);

    // Positive signed overflow
    applyStimulus(8'h7F, 8'h01, 1'b0);
    step();
    checkOutput("povf_out_valid", {31'b0, out_valid}, 1);
`ifdef ADDER_PIPE_SAT_EN
    checkOutput("povf_sum", {24'b0, sum}, 32'h7F);
`else
    checkOutput("povf_sum", {24'b0, sum}, 32'h80);
`endif
    checkOutput("povf_ovf", {31'b0, ovf}, 1);
    checkOutput("povf_cout", {31'b0, cout}, 0);

    // Unsigned wrap, no signed overflow
    applyStimulus(8'hFF, 8'h01, 1'b0);
    step();
    checkOutput("wrap_sum", {24'b0, sum}, 0);
    checkOutput("wrap_cout", {31'b0, cout}, 1);
    checkOutput("wrap_ovf", {31'b0, ovf}, 0);

    // Carry-in rippling across the chunk boundary
    applyStimulus(8'hFF, 8'h00, 1'b1);
    step();
    checkOutput("cin_chain_sum", {24'b0, sum}, 0);
    checkOutput("cin_chain_cout", {31'b0, cout}, 1);
    checkOutput("cin_chain_ovf", {31'b0, ovf}, 0);

    // Negative signed overflow
    applyStimulus(8'h80, 8'h80, 1'b0);
    step();
`ifdef ADDER_PIPE_SAT_EN
    checkOutput("novf_sum", {24'b0, sum}, 32'h80);
`else
    checkOutput("novf_sum", {24'b0, sum}, 32'h00);
`endif
    checkOutput("novf_cout", {31'b0, cout}, 1);
    checkOutput("novf_ovf", {31'b0, ovf}, 1);
    step();
    checkOutput("drained_out_valid", {31'b0, out_valid}, 0);

    // Backpressure: pipe fills with two beats and holds
    out_ready = 1'b0;
    accepted  = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid  = 1'b1;
      a         = 8'(accepted + 1);
      b         = 8'(accepted + 1);
      cin       = 1'b0;
      was_ready = in_ready;
      step();
      if (was_ready) accepted++;
      if (cyc >= 2) begin
        checkOutput("bp_in_ready_low", {31'b0, in_ready}, 0);
        checkOutput("bp_out_valid", {31'b0, out_valid}, 1);
        checkOutput("bp_hold_sum", {24'b0, sum}, 2);
      end
    end
    checkOutput("bp_accepted", accepted, 2);

    out_ready = 1'b1;
    #0;
    checkOutput("bp_full_in_ready", {31'b0, in_ready}, 1);
    got = 0;
    for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
      if (accepted < 4) begin
        in_valid = 1'b1;
        a        = 8'(accepted + 1);
        b        = 8'(accepted + 1);
      end else begin
        in_valid = 1'b0;
      end
      was_ready = in_ready;
      if (out_valid) begin
        results[got] = sum;
        got++;
      end
      step();
      if (was_ready && in_valid) accepted++;
    end
    in_valid = 1'b0;
    checkOutput("bp_result_count", got, 4);
    for (int i = 0; i < 4; i++) checkOutput("bp_result_order", {24'b0, results[i]}, 2 * (i + 1));
    checkOutput("bp_no_duplicate", {31'b0, out_valid}, 0);

    // Throughput: 16 back-to-back random beats
    first_out = -1;
    last_out  = -1;
    outs      = 0;
    not_ready = 0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      if (cyc < 16) begin
        rx       = 8'($urandom_range(0, 255));
        ry       = 8'($urandom_range(0, 255));
        rc       = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        a        = rx;
        b        = ry;
        cin      = rc;
        if (!in_ready) not_ready++;
        exp_q.push_back(model(rx, ry, rc));
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        outs++;
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          checkOutput("tp_sum", {24'b0, sum}, {24'b0, exp_v[7:0]});
          checkOutput("tp_cout", {31'b0, cout}, {31'b0, exp_v[8]});
          checkOutput("tp_ovf", {31'b0, ovf}, {31'b0, exp_v[9]});
        end else begin
          checkOutput("tp_unexpected_out", {31'b0, out_valid}, 0);
        end
      end
      step();
    end
    checkOutput("tp_in_ready_stalls", not_ready, 0);
    checkOutput("tp_first_out_cycle", first_out, 2);
    checkOutput("tp_last_out_cycle", last_out, 17);
    checkOutput("tp_out_count", outs, 16);

    // Asynchronous reset with two beats in flight
    out_ready = 1'b0;
    applyStimulus(8'd10, 8'd20, 1'b0);
    applyStimulus(8'd30, 8'd40, 1'b0);
    checkOutput("rst_pre_out_valid", {31'b0, out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_out_valid", {31'b0, out_valid}, 0);
    checkOutput("rst_async_sum", {24'b0, sum}, 0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("rst_release_in_ready", {31'b0, in_ready}, 1);
    got = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step();
      if (out_valid) got++;
    end
    checkOutput("rst_no_stale_result", got, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the combinational `adder`.
- Adds two WIDTH-bit operands plus carry-in. The carry chain is split across STAGES register stages.
- Valid/ready handshake on input and output. Reports carry-out and signed overflow.
- Sits between file-driven/stream sources and result sinks. Full throughput: one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 2, number of pipeline stages (1..4); each stage resolves CHUNK = WIDTH/STAGES bits.
- SIGNED, 1, 1: ovf flags two's-complement overflow; 0: ovf mirrors cout.

Ports:
- clk  in  1  single clock (one clock; reset is asynchronous and active-low).
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB.
- ovf  out  1  overflow flag (per SIGNED).

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once rst_n is high. In-flight beats are discarded; no result emerges after release.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - a/b/cin are sampled only on an input transfer.
- Stage k (0-based):
  - Adds chunk k of the delayed a and b, plus the carry registered from stage k-1. Stage 0 uses cin.
  - Chunk k's result bits are stored. Lower chunks are forwarded; upper operand chunks are delayed alongside.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stall.
- Stall rule: ready_k = !valid_k || ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0.
  - Bubbles collapse.
  - Order is preserved.
  - Outputs hold stable while out_valid && !out_ready.
- Capacity: STAGES beats in flight. With out_ready held low, in_ready drops after STAGES accepted beats.
- Simultaneous output transfer and input transfer on a full pipe: both occur and the pipe stays full; in_ready stays 1.
- Arithmetic:
  - Full sum = a + b + cin, modulo 2^WIDTH.
  - cout = bit WIDTH of the unsigned sum.
  - SIGNED=1: ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - SIGNED=0: ovf = cout.
- STAGES=1: purely registered adder, latency 1.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- Defined: on ovf, sum saturates.
  - SIGNED=1: positive overflow gives 0x7F..F; negative overflow gives 0x80..0.
  - SIGNED=0: all-ones.
  - ovf and cout still report the raw event.
- Undefined: sum wraps modulo 2^WIDTH. Saturation logic is absent.

Decomposition:
- Package adder_pkg:
  - CHUNK width function of (WIDTH, STAGES).
  - Stage payload struct typedef: partial sum, remaining a/b, carry, valid.
  - Saturation constant functions (max/min for width).
- One natural sub-module: adder_pipe_stage (one chunk add + payload register + ready logic), instantiated STAGES times via generate.
- Top-level final-stage overflow/saturation logic stays in adder_pipe.

Test Plan:
- Basic add: WIDTH=8, STAGES=2, a=100, b=27, cin=0, out_ready=1 → after 2 cycles sum=127, cout=0, ovf=0.
- Signed overflow: a=0x7F, b=0x01 → sum=0x80, ovf=1, cout=0. With ADDER_PIPE_SAT_EN: sum=0x7F, ovf=1.
- Carry/wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1 (carry crosses the chunk boundary).
- Backpressure: stream (1,1),(2,2),(3,3),(4,4) with out_ready low for 5 cycles → in_ready=0 after 2 accepts, sum stable. On release, results 2,4,6,8 arrive in order with no loss or duplication.
- Throughput: 16 back-to-back random beats with out_ready=1 → 16 consecutive out_valid cycles starting 2 cycles after the first accept, each matching the reference model (a+b+cin).
- Reset mid-operation: two beats in flight, pulse rst_n low asynchronously between clock edges → out_valid=0 immediately. After release, in_ready=1 and no stale result appears.
